// File: rtl/irq_controller_if.sv
// Bundle of interrupt sources, config port and pipeline handshake for irq_controller.
// slave = controller side, master = pipeline/stimulus side.
interface irq_controller_if #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic [N_IRQ-1:0] ext_irq;
  logic             gie;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [N_IRQ-1:0] cfg_wdata;
  logic             irq_ack;
  logic             irq_done;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      irq_addr;
  logic             in_service;
  logic [N_IRQ-1:0] irq_pending;

  modport slave (
    input  ext_irq, gie, cfg_we, cfg_sel, cfg_wdata, irq_ack, irq_done,
    output irq_req, irq_id, irq_addr, in_service, irq_pending
  );
  modport master (
    output ext_irq, gie, cfg_we, cfg_sel, cfg_wdata, irq_ack, irq_done,
    input  irq_req, irq_id, irq_addr, in_service, irq_pending
  );
endinterface

// File: rtl/irq_controller.sv
// Multi-channel external interrupt controller: sync, edge/level pending latch,
// fixed lowest-index priority and a non-nesting REQ/SERVICE handshake.
module irq_controller #(
  parameter int          N_IRQ       = 8,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  irq_controller_if.slave bus
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] prev_q, en_q, edge_q, pending_q, pending_d;
  logic [N_IRQ-1:0] synced, rise, cand;
  state_e           state_q;
  logic             irq_req_q, in_service_q;
  logic [ID_W-1:0]  irq_id_q, win_id;
  logic [31:0]      irq_addr_q, win_addr;
  logic             ack_take;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev_q;
  assign cand     = pending_q & en_q;
  assign ack_take = (state_q == REQ) && bus.irq_ack;

  always_comb begin
    win_id = '0;
    for (int i = N_IRQ-1; i >= 0; i--)
      if (cand[i]) win_id = ID_W'(i);
  end

  assign win_addr = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);

  // Edge channels: a same-cycle rising edge beats ack/W1C clear so no edge is lost.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      logic clr;
      clr = (ack_take && (irq_id_q == ID_W'(i))) ||
            (bus.cfg_we && (bus.cfg_sel == 2'd2) && bus.cfg_wdata[i]);
      if (edge_q[i]) pending_d[i] = rise[i] | (pending_q[i] & ~clr);
      else           pending_d[i] = synced[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      en_q      <= '0;
      edge_q    <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq};
      prev_q    <= synced;
      pending_q <= pending_d;
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0:    en_q   <= bus.cfg_wdata;
          2'd1:    edge_q <= bus.cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  // REQ never withdraws: id/addr stay frozen until the pipeline acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      irq_addr_q   <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.gie && |cand) begin
          irq_id_q   <= win_id;
          irq_addr_q <= win_addr;
          irq_req_q  <= 1'b1;
          state_q    <= REQ;
        end
        REQ: if (bus.irq_ack) begin
          irq_req_q    <= 1'b0;
          in_service_q <= 1'b1;
          state_q      <= SERVICE;
        end
        SERVICE: if (bus.irq_done) begin
          in_service_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.irq_req     = irq_req_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.irq_addr    = irq_addr_q;
  assign bus.in_service  = in_service_q;
  assign bus.irq_pending = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed checks of irq_controller: latency, priority, level/edge, gie, collisions, async reset.
module tb_irq_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  irq_controller_if #(.N_IRQ(8)) bus();

  irq_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    bus.ext_irq = m;
    tick();
    bus.ext_irq = '0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
  endtask

  task automatic done();
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
  endtask

  initial begin
    bus.ext_irq = '0; bus.gie = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sel = '0;
    bus.cfg_wdata = '0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    tick(2);
    chk("rst_req", 32'(bus.irq_req), 32'd0);
    chk("rst_addr", bus.irq_addr, 32'd0);
    chk("rst_pend", 32'(bus.irq_pending), 32'd0);
    rst = 1'b0;
    tick();

    // Edge ch3: 4-cycle latency, vector 0x10C
    cfg(2'd0, 8'h08); cfg(2'd1, 8'h08);
    bus.gie = 1'b1;
    pulse(8'h08);
    tick(2);
    chk("e3_pend_edge3", 32'(bus.irq_pending), 32'h08);
    chk("e3_noreq_edge3", 32'(bus.irq_req), 32'd0);
    tick();
    chk("e3_req", 32'(bus.irq_req), 32'd1);
    chk("e3_id", 32'(bus.irq_id), 32'd3);
    chk("e3_addr", bus.irq_addr, 32'h10C);
    ack();
    chk("e3_ack_req", 32'(bus.irq_req), 32'd0);
    chk("e3_ack_insvc", 32'(bus.in_service), 32'd1);
    chk("e3_ack_pend", 32'(bus.irq_pending), 32'h00);
    done();
    chk("e3_done_insvc", 32'(bus.in_service), 32'd0);
    tick();
    chk("e3_idle_req", 32'(bus.irq_req), 32'd0);

    // Priority: ch5 and ch2 together
    cfg(2'd0, 8'h2C); cfg(2'd1, 8'h2C);
    pulse(8'h24);
    tick(3);
    chk("pri_id_a", 32'(bus.irq_id), 32'd2);
    chk("pri_addr_a", bus.irq_addr, 32'h108);
    ack(); done();
    chk("pri_idle_gap", 32'(bus.irq_req), 32'd0);
    tick();
    chk("pri_req_b", 32'(bus.irq_req), 32'd1);
    chk("pri_id_b", 32'(bus.irq_id), 32'd5);
    chk("pri_addr_b", bus.irq_addr, 32'h114);
    ack(); done();

    // Level ch0
    cfg(2'd0, 8'h01); cfg(2'd1, 8'h00);
    bus.ext_irq = 8'h01;
    tick(4);
    chk("lvl_req", 32'(bus.irq_req), 32'd1);
    chk("lvl_addr", bus.irq_addr, 32'h100);
    ack(); done();
    tick();
    chk("lvl_rereq", 32'(bus.irq_req), 32'd1);
    ack();
    chk("lvl_pend_after_ack", 32'(bus.irq_pending), 32'h01);
    bus.ext_irq = '0;
    tick(3);
    chk("lvl_pend_drop", 32'(bus.irq_pending), 32'h00);
    done(); tick(2);
    chk("lvl_no_rereq", 32'(bus.irq_req), 32'd0);

    // gie gating on ch1
    bus.gie = 1'b0;
    cfg(2'd0, 8'h02); cfg(2'd1, 8'h02);
    pulse(8'h02);
    tick(4);
    chk("gie_pend", 32'(bus.irq_pending), 32'h02);
    chk("gie_noreq", 32'(bus.irq_req), 32'd0);
    bus.gie = 1'b1;
    tick();
    chk("gie_req", 32'(bus.irq_req), 32'd1);
    chk("gie_id", 32'(bus.irq_id), 32'd1);
    bus.gie = 1'b0;
    tick(2);
    chk("gie_held", 32'(bus.irq_req), 32'd1);
    chk("gie_held_id", 32'(bus.irq_id), 32'd1);
    ack(); done();
    bus.gie = 1'b1;

    // Collision ch3: new edge lands with ack
    cfg(2'd0, 8'h08); cfg(2'd1, 8'h08);
    pulse(8'h08);
    tick(3);
    chk("col_req", 32'(bus.irq_req), 32'd1);
    pulse(8'h08);
    tick();
    ack();
    chk("col_ack_pend", 32'(bus.irq_pending), 32'h08);
    chk("col_ack_insvc", 32'(bus.in_service), 32'd1);
    done(); tick();
    chk("col_rereq", 32'(bus.irq_req), 32'd1);
    chk("col_rereq_id", 32'(bus.irq_id), 32'd3);
    ack();
    chk("col_clear", 32'(bus.irq_pending), 32'h00);
    done();
    // New edge lands with W1C
    pulse(8'h08);
    tick();
    cfg(2'd2, 8'h08);
    chk("w1c_pend", 32'(bus.irq_pending), 32'h08);
    tick();
    chk("w1c_req", 32'(bus.irq_req), 32'd1);
    ack();
    chk("pre_rst_insvc", 32'(bus.in_service), 32'd1);

    // Async reset while in SERVICE
    rst = 1'b1;
    #2;
    chk("arst_insvc", 32'(bus.in_service), 32'd0);
    chk("arst_req", 32'(bus.irq_req), 32'd0);
    chk("arst_id", 32'(bus.irq_id), 32'd0);
    chk("arst_addr", bus.irq_addr, 32'd0);
    tick();
    rst = 1'b0;
    cfg(2'd0, 8'hFF);
    tick(5);
    chk("post_rst_noreq", 32'(bus.irq_req), 32'd0);
    chk("post_rst_pend", 32'(bus.irq_pending), 32'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
